// File: rtl/pe_pkg.sv
// Shared defaults and saturation-bound helpers for the MAC tile.
// Bounds are returned 64 bits wide; callers size-cast to their accumulator width.
package pe_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 20;
  localparam int K_LEN_DEF  = 4;

  // Largest representable accumulator value for a w-bit signed/unsigned number.
  function automatic logic [63:0] sat_max(input int w, input bit sgn);
    logic [63:0] one;
    one = 64'd1;
    return sgn ? ((one << (w - 1)) - one) : ((one << w) - one);
  endfunction

  function automatic logic [63:0] sat_min(input int w, input bit sgn);
    logic [63:0] one;
    one = 64'd1;
    return sgn ? ~((one << (w - 1)) - one) : 64'd0;
  endfunction

endpackage

// File: rtl/pe_mult.sv
// Combinational full-width multiplier, signed or unsigned per parameter.
// Result is exactly 2*DATA_W bits; no truncation or rounding.
module pe_mult
  import pe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SIGNED = 0
) (
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [2*DATA_W-1:0] p
);

  if (SIGNED != 0) begin : g_signed
    logic signed [2*DATA_W-1:0] sa;
    logic signed [2*DATA_W-1:0] sb;
    assign sa = {{DATA_W{a[DATA_W-1]}}, a};
    assign sb = {{DATA_W{b[DATA_W-1]}}, b};
    assign p  = sa * sb;
  end else begin : g_unsigned
    logic [2*DATA_W-1:0] ua;
    logic [2*DATA_W-1:0] ub;
    assign ua = {{DATA_W{1'b0}}, a};
    assign ub = {{DATA_W{1'b0}}, b};
    assign p  = ua * ub;
  end

endmodule

// File: rtl/pe_mac_tile.sv
// Systolic processing element: forwards a/b/valid one cycle, accumulates K_LEN products per tile.
// Tile result is registered and pulsed on out_valid one cycle after the K_LEN-th sample.
module pe_mac_tile
  import pe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int K_LEN  = K_LEN_DEF,
  parameter int SIGNED = 0,
  parameter int SAT    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              clear,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              valid_out,
  output logic [ACC_W-1:0]  out,
  output logic              out_valid,
  output logic              overflow
);

  localparam int                 CNT_W    = (K_LEN > 1) ? $clog2(K_LEN) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(K_LEN - 1);
  localparam logic [ACC_W-1:0]   ACC_MAX  = ACC_W'(sat_max(ACC_W, SIGNED != 0));
  localparam logic [ACC_W-1:0]   ACC_MIN  = ACC_W'(sat_min(ACC_W, SIGNED != 0));

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    prod_ext;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    base;
  logic [ACC_W-1:0]    raw;
  logic [ACC_W-1:0]    clamp;
  logic [ACC_W-1:0]    sum;
  logic [ACC_W:0]      sum_w;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_base;
  logic                add_ovf;
  logic                ovf_base;
  logic                last;

  pe_mult #(
    .DATA_W(DATA_W),
    .SIGNED(SIGNED)
  ) u_mult (
    .a(a),
    .b(b),
    .p(prod)
  );

  if (SIGNED != 0) begin : g_sext
    assign prod_ext = ACC_W'($signed(prod));
  end else begin : g_zext
    assign prod_ext = ACC_W'(prod);
  end

  // clear restarts the tile in the same cycle, so a concurrent sample sees an empty tile.
  always_comb begin
    base     = clear ? '0 : acc;
    cnt_base = clear ? '0 : cnt;
    ovf_base = (clear || out_valid) ? 1'b0 : overflow;
    sum_w    = {1'b0, base} + {1'b0, prod_ext};
    raw      = sum_w[ACC_W-1:0];
    add_ovf  = 1'b0;
    clamp    = ACC_MAX;
    if (SIGNED != 0) begin
      add_ovf = (base[ACC_W-1] == prod_ext[ACC_W-1]) && (raw[ACC_W-1] != base[ACC_W-1]);
      clamp   = base[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end else begin
      add_ovf = sum_w[ACC_W];
    end
    sum  = ((SAT != 0) && add_ovf) ? clamp : raw;
    last = (cnt_base == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_out     <= '0;
      b_out     <= '0;
      valid_out <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      a_out     <= a;
      b_out     <= b;
      valid_out <= in_valid;
      out_valid <= 1'b0;
      overflow  <= ovf_base;
      acc       <= base;
      cnt       <= cnt_base;
      if (in_valid) begin
        overflow <= ovf_base | add_ovf;
        if (last) begin
          out       <= sum;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt_base + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/pe_mac_tile.md
PE_MAC_TILE -- requirements
Module: pe_mac_tile

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand width in bits.
REQ-002 SHALL have parameter ACC_W, default 20, accumulator width in bits; legal only if ACC_W >= 2*DATA_W.
REQ-003 SHALL have parameter K_LEN, default 4, number of valid samples per tile; legal range 1..255.
REQ-004 SHALL have parameter SIGNED, default 0; 0 = unsigned operands, 1 = two's-complement operands.
REQ-005 SHALL have parameter SAT, default 0; 0 = accumulator wraps, 1 = accumulator saturates.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 in_valid  input  1  a/b carry a sample this cycle.
REQ-009 a  input  DATA_W  row operand.
REQ-010 b  input  DATA_W  column operand.
REQ-011 clear  input  1  abort current tile; restart count and accumulator.
REQ-012 a_out  output  DATA_W  registered a, to the east neighbour.
REQ-013 b_out  output  DATA_W  registered b, to the south neighbour.
REQ-014 valid_out  output  1  registered in_valid, to neighbours.
REQ-015 out  output  ACC_W  last completed tile result.
REQ-016 out_valid  output  1  one-cycle pulse: out updated this cycle.
REQ-017 overflow  output  1  sticky: wrap or clamp occurred in current tile.

Function
REQ-018 a_out, b_out, valid_out SHALL equal a, b, in_valid delayed exactly one cycle, unconditionally (forwarded even when in_valid=0).
REQ-019 Product SHALL be full 2*DATA_W bits, sign- or zero-extended per SIGNED to ACC_W before addition.
REQ-020 Internal accumulator acc (ACC_W) and sample counter cnt (0..K_LEN-1) SHALL be the only tile state; cnt counts only cycles with in_valid=1.
REQ-021 On in_valid=1 with cnt < K_LEN-1 and clear=0: acc <= acc+product, cnt <= cnt+1.
REQ-022 On in_valid=1 with cnt = K_LEN-1 and clear=0: out <= acc+product, out_valid=1 next cycle (registered, single cycle), acc <= 0, cnt <= 0.
REQ-023 Latency: out/out_valid SHALL appear one cycle after the edge capturing the K_LEN-th valid sample.
REQ-024 in_valid=0 cycles SHALL hold acc and cnt; gaps of any length between samples are legal.
REQ-025 clear=1 SHALL set cnt <= 0, acc <= 0, overflow <= 0, discarding the partial tile; out keeps its last value; out_valid=0.
REQ-026 clear=1 with in_valid=1 in the same cycle SHALL take the sample as the first of the new tile: acc <= product, cnt <= 1 (or tile completes immediately if K_LEN=1).
REQ-027 SAT=0: sum SHALL wrap modulo 2^ACC_W; SAT=1: sum SHALL clamp to max/min representable value per SIGNED.
REQ-028 overflow SHALL set on any wrapping or clamping addition and remain set until tile completion's following first sample, clear, or rst; on tile completion, overflow reflects the completed tile during the out_valid cycle, then clears.
REQ-029 K_LEN=1 SHALL produce out=product and out_valid for every valid sample.

Reset
REQ-030 rst SHALL set a_out=0, b_out=0, valid_out=0, out=0, out_valid=0, overflow=0, acc=0, cnt=0 at the next rising edge.
REQ-031 rst SHALL dominate clear and in_valid; a tile in progress is discarded and the sample in the reset cycle is dropped.

Structure
REQ-032 Default widths, K_LEN and the saturation-bound helper functions SHALL live in shared package pe_pkg.
REQ-033 Multiplication SHALL be a combinational sub-module pe_mult (DATA_W, SIGNED parameters, 2*DATA_W output); all registers live in pe_mac_tile.

Verification
REQ-034 Defaults, samples (3,4),(5,6),(1,1),(2,10) back-to-back -> out=12+30+1+20=63, out_valid single pulse one cycle after 4th sample, overflow=0.
REQ-035 Same samples with 2 idle cycles between each -> identical out=63; a_out/b_out/valid_out track inputs with 1-cycle delay throughout.
REQ-036 Two samples then clear=1 with in_valid=1 carrying (7,7), then three samples of (1,1) -> out=52, no earlier out_valid.
REQ-037 DATA_W=8, ACC_W=16, SAT=1, four samples (255,255) -> out=65535, overflow=1 in out_valid cycle; SAT=0 -> out=(4*65025) mod 65536=63492, overflow=1.
REQ-038 SIGNED=1, samples (-3,4),(2,-5),(-1,-1),(0,9) -> out=-21 (two's complement in ACC_W).
REQ-039 rst asserted after two samples, then four samples (1,2) -> all outputs 0 during reset, then out=8.
